maxpool_reader: RTL and testbench
=================================

// Module: maxpool_reader
// PURPOSE
//  Layer1 engine: reads the Layer0 conv map (ReLU'd 20-bit words written by the
//  conv accumulator) from Layer0 memory, computes 2x2 stride-2 max pooling, and
//  writes the pooled map to Layer1 memory. Sits between the Layer0 memory read
//  port and the Layer1 memory write port; launched once per image by the top FSM.
// PARAMETERS
//  IMG_W   64  Layer0 map width = height (even, power of 2, >=4)
//  DW      20  data width (signed Q4.16)
//  AW      12  Layer0 address width, = log2(IMG_W*IMG_W)
// PORTS
//  clk       in   1    clock, rising edge
//  reset     in   1    synchronous, active-high
//  start     in   1    1-cycle launch pulse; ignored while busy
//  busy      out  1    high while pooling in progress
//  done      out  1    1-cycle pulse after final write
//  crd       out  1    Layer0 read strobe
//  caddr_rd  out  AW   Layer0 read address, row-major
//  cdata_rd  in   DW   Layer0 read data, valid exactly 1 cycle after crd
//  cwr       out  1    Layer1 write strobe
//  caddr_wr  out  AW-2 Layer1 write address, row-major, width IMG_W/2
//  cdata_wr  out  DW   pooled value
// BEHAVIOUR
//  Reset: state IDLE; busy, done, crd, cwr = 0; caddr_rd, caddr_wr, cdata_wr, max
//   register, row/col counters = 0. Reset mid-operation aborts immediately; no
//   write or done is produced for the aborted image.
//  States: IDLE -> RD0 -> RD1 -> RD2 -> RD3 -> LAST -> WR -> (RD0 | FIN) ; FIN -> IDLE.
//  IDLE: start=1 -> RD0 next cycle, busy=1 from that cycle; r=c=0.
//  RDk (k=0..3): crd=1, caddr_rd = base + {0, 1, IMG_W, IMG_W+1}[k],
//   base = 2r*IMG_W + 2c. Window order: top-left, top-right, bottom-left, bottom-right.
//  Capture: in the cycle after RDk, cdata_rd is sampled (RD1,RD2,RD3,LAST capture
//   k=0..3). k=0 loads max; k>0: max <= (cdata_rd > max) ? cdata_rd : max.
//   Signed compare; on tie earlier value kept (result value identical).
//  LAST: crd=0, captures k=3.
//  WR: cwr=1 one cycle, caddr_wr = r*(IMG_W/2)+c, cdata_wr = max (registered,
//   held until next WR). Then c++; on c wrap (IMG_W/2-1 -> 0) r++.
//   Last window (r=c=IMG_W/2-1) -> FIN, else -> RD0.
//  FIN: done=1 one cycle, busy=0 same cycle; -> IDLE. busy = 1 in RD0..WR only.
//  Cost: 6 cycles per output; full image = 6*(IMG_W/2)^2 + 1 cycles start->done
//   (6145 for IMG_W=64). crd and cwr never high in the same cycle.
//  start during busy/FIN: ignored, no restart. start in same cycle as reset: reset wins.
//  No arithmetic beyond compare; cdata_wr is a copy of one input word (no rounding).
// TESTING
//  T1 IMG_W=4, Layer0 model = addr value (0..15), start -> 4 writes:
//     (addr0,5) (addr1,7) (addr2,13) (addr3,15); done 25 cycles after start.
//  T2 read-address trace IMG_W=4, window (r=1,c=1): crd addrs 10,11,14,15 in order,
//     one per cycle, cdata_rd latency 1 honoured.
//  T3 signed/tie: window {-3,-3,-1,-7} (20'hFFFFD..) -> cdata_wr = 20'hFFFFF;
//     window {8,8,8,8} -> 8; max in each corner position in turn -> that value.
//  T4 reset asserted 3 cycles into second window -> next cycle busy=0,crd=0,cwr=0,
//     no further writes, no done; new start re-runs from window 0 correctly.
//  T5 start pulsed every cycle while busy -> exactly (IMG_W/2)^2 writes, one done.
//  T6 IMG_W=64 random nonneg data vs golden maxpool -> all 1024 writes match,
//     done 6145 cycles after start, crd/cwr never simultaneous.

Source files
------------

// File: rtl/maxpool_reader.sv
// 2x2 stride-2 max pooling from the Layer0 map into the Layer1 map.
// Six cycles per output (4 reads, 1 capture, 1 write). There is no backpressure; reads have a fixed 1-cycle latency.
module maxpool_reader #(
  parameter int IMG_W = 64,
  parameter int DW    = 20,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-3:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam int CW = $clog2(IMG_W) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        r_q, r_d, c_q, c_d;
  logic signed [DW-1:0] max_q, max_d, dat_q, dat_d;
  logic [AW-3:0]        waddr_q, waddr_d;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] greater;
  logic                 last_win;

  assign din      = cdata_rd;
  // A tie keeps the earlier word, which has the same value anyway.
  assign greater  = (din > max_q) ? din : max_q;
  assign last_win = (r_q == {CW{1'b1}}) && (c_q == {CW{1'b1}});
  assign caddr_wr = waddr_q;
  assign cdata_wr = dat_q;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    max_d    = max_q;
    dat_d    = dat_q;
    waddr_d  = waddr_q;
    busy     = 1'b0;
    done     = 1'b0;
    crd      = 1'b0;
    cwr      = 1'b0;
    caddr_rd = '0;
    // Read address is {2r + row_off, 2c + col_off}. The row-major layout makes the offsets plain bits.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_RD0: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = {r_q, 1'b0, c_q, 1'b0};
        state_d  = S_RD1;
      end
      S_RD1: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = {r_q, 1'b0, c_q, 1'b1};
        max_d    = din;
        state_d  = S_RD2;
      end
      S_RD2: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = {r_q, 1'b1, c_q, 1'b0};
        max_d    = greater;
        state_d  = S_RD3;
      end
      S_RD3: begin
        busy     = 1'b1;
        crd      = 1'b1;
        caddr_rd = {r_q, 1'b1, c_q, 1'b1};
        max_d    = greater;
        state_d  = S_LAST;
      end
      S_LAST: begin
        busy    = 1'b1;
        max_d   = greater;
        dat_d   = greater;
        waddr_d = {r_q, c_q};
        state_d = S_WR;
      end
      S_WR: begin
        busy       = 1'b1;
        cwr        = 1'b1;
        {r_d, c_d} = {r_q, c_q} + (2*CW)'(1);
        state_d    = last_win ? S_FIN : S_RD0;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      max_q   <= '0;
      dat_q   <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      max_q   <= max_d;
      dat_q   <= dat_d;
      waddr_q <= waddr_d;
    end
  end

endmodule

// File: tb/tb_maxpool_reader.sv
// Directed bench for maxpool_reader: a 4x4 instance for the detailed scenarios and a 64x64 instance for a whole image.
module tb_maxpool_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start4, busy4, done4, crd4, cwr4;
  logic [3:0]  caddr_rd4;
  logic [19:0] cdata_rd4, cdata_wr4;
  logic [1:0]  caddr_wr4;
  logic        start64, busy64, done64, crd64, cwr64;
  logic [11:0] caddr_rd64;
  logic [19:0] cdata_rd64, cdata_wr64;
  logic [9:0]  caddr_wr64;

  maxpool_reader #(.IMG_W(4), .DW(20), .AW(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .crd(crd4), .caddr_rd(caddr_rd4), .cdata_rd(cdata_rd4),
    .cwr(cwr4), .caddr_wr(caddr_wr4), .cdata_wr(cdata_wr4));

  maxpool_reader #(.IMG_W(64), .DW(20), .AW(12)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .busy(busy64), .done(done64),
    .crd(crd64), .caddr_rd(caddr_rd64), .cdata_rd(cdata_rd64),
    .cwr(cwr64), .caddr_wr(caddr_wr64), .cdata_wr(cdata_wr64));

  logic [19:0] mem4 [16];
  logic [19:0] mem64 [4096];

  // Read data is only defined the cycle after a strobe; X elsewhere exposes mistimed captures.
  always @(posedge clk) begin
    cdata_rd4  <= crd4  ? mem4[caddr_rd4]   : 'x;
    cdata_rd64 <= crd64 ? mem64[caddr_rd64] : 'x;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  wa4_q [$];
  logic [19:0] wd4_q [$];
  logic [3:0]  ra4_q [$];
  int          rc4_q [$];
  logic [9:0]  wa64_q [$];
  logic [19:0] wd64_q [$];
  int n_done4, n_done64, n_ovl4, n_ovl64;

  always @(negedge clk) begin
    if (cwr4) begin wa4_q.push_back(caddr_wr4); wd4_q.push_back(cdata_wr4); end
    if (crd4) begin ra4_q.push_back(caddr_rd4); rc4_q.push_back(cyc); end
    if (cwr64) begin wa64_q.push_back(caddr_wr64); wd64_q.push_back(cdata_wr64); end
    if (done4) n_done4++;
    if (done64) n_done64++;
    if (crd4 && cwr4) n_ovl4++;
    if (crd64 && cwr64) n_ovl64++;
  end

  int checks = 0;
  int failures = 0;

  task automatic clear_mon();
    wa4_q.delete(); wd4_q.delete(); ra4_q.delete(); rc4_q.delete();
    wa64_q.delete(); wd64_q.delete();
    n_done4 = 0; n_done64 = 0; n_ovl4 = 0; n_ovl64 = 0;
  endtask

  task automatic fill_identity4();
    for (int i = 0; i < 16; i++) mem4[i] = 20'(i);
  endtask

  task automatic set_win(input int r, input int c, input int tl, input int tr, input int bl, input int br);
    int b;
    b = 8*r + 2*c;
    mem4[b] = 20'(tl); mem4[b+1] = 20'(tr); mem4[b+4] = 20'(bl); mem4[b+5] = 20'(br);
  endtask

  // Pulses start and returns how many cycles later done was seen (cycle of start = 0).
  task automatic run4(output int n);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; n = 1;
    while (!done4 && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; start4 = 1'b1; start64 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done4); end
    checks++; if ({crd4, cwr4} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {crd4, cwr4}); end
    checks++; if (caddr_rd4 !== 4'd0) begin failures++; $display("FAIL rst_caddr_rd got=%0h exp=0", caddr_rd4); end
    checks++; if (caddr_wr4 !== 2'd0) begin failures++; $display("FAIL rst_caddr_wr got=%0h exp=0", caddr_wr4); end
    checks++; if (cdata_wr4 !== 20'd0) begin failures++; $display("FAIL rst_cdata_wr got=%0h exp=0", cdata_wr4); end
    checks++; if (busy64 !== 1'b0) begin failures++; $display("FAIL rst_busy64 got=%b exp=0", busy64); end
    start4 = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_start_ignored got=%b exp=0", busy4); end
  endtask

  task automatic test_basic();
    int n;
    int exp_d [4] = '{5, 7, 13, 15};
    fill_identity4(); clear_mon();
    run4(n);
    checks++; if (n !== 25) begin failures++; $display("FAIL basic_latency got=%0d exp=25", n); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy4); end
    @(negedge clk);
    checks++; if (n_done4 !== 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done4); end
    checks++; if (wa4_q.size() !== 4) begin failures++; $display("FAIL basic_wr_count got=%0d exp=4", wa4_q.size()); end
    for (int i = 0; i < 4 && i < wa4_q.size(); i++) begin
      checks++; if (wa4_q[i] !== 2'(i)) begin failures++; $display("FAIL basic_waddr%0d got=%0d exp=%0d", i, wa4_q[i], i); end
      checks++; if (wd4_q[i] !== 20'(exp_d[i])) begin failures++; $display("FAIL basic_wdata%0d got=%0d exp=%0d", i, wd4_q[i], exp_d[i]); end
    end
    checks++; if (n_ovl4 !== 0) begin failures++; $display("FAIL basic_overlap got=%0d exp=0", n_ovl4); end
  endtask

  task automatic test_addr_trace();
    int n;
    int exp_a [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    fill_identity4(); clear_mon();
    run4(n);
    checks++; if (ra4_q.size() !== 16) begin failures++; $display("FAIL trace_count got=%0d exp=16", ra4_q.size()); end
    for (int i = 0; i < 16 && i < ra4_q.size(); i++) begin
      checks++; if (ra4_q[i] !== 4'(exp_a[i])) begin failures++; $display("FAIL trace_addr%0d got=%0d exp=%0d", i, ra4_q[i], exp_a[i]); end
    end
    if (ra4_q.size() == 16) begin
      checks++; if (rc4_q[15] - rc4_q[12] !== 3) begin failures++; $display("FAIL trace_back_to_back got=%0d exp=3", rc4_q[15] - rc4_q[12]); end
    end
  endtask

  task automatic test_signed_tie();
    int n;
    logic [19:0] exp_a [4] = '{20'hFFFFF, 20'd8, 20'd9, 20'd6};
    logic [19:0] exp_b [4] = '{20'd12, 20'd17, 20'hFFFEC, 20'd4};
    set_win(0, 0, -3, -3, -1, -7);
    set_win(0, 1, 8, 8, 8, 8);
    set_win(1, 0, 9, -2, 3, 1);
    set_win(1, 1, -5, 6, 2, -1);
    clear_mon(); run4(n); @(negedge clk);
    checks++; if (wd4_q.size() !== 4) begin failures++; $display("FAIL sgn_a_count got=%0d exp=4", wd4_q.size()); end
    for (int i = 0; i < 4 && i < wd4_q.size(); i++) begin
      checks++; if (wd4_q[i] !== exp_a[i]) begin failures++; $display("FAIL sgn_a%0d got=%0h exp=%0h", i, wd4_q[i], exp_a[i]); end
    end
    set_win(0, 0, 1, 2, 12, -4);
    set_win(0, 1, 0, 3, 2, 17);
    set_win(1, 0, -20, -30, -40, -50);
    set_win(1, 1, 4, 1, 2, 4);
    clear_mon(); run4(n); @(negedge clk);
    checks++; if (wd4_q.size() !== 4) begin failures++; $display("FAIL sgn_b_count got=%0d exp=4", wd4_q.size()); end
    for (int i = 0; i < 4 && i < wd4_q.size(); i++) begin
      checks++; if (wd4_q[i] !== exp_b[i]) begin failures++; $display("FAIL sgn_b%0d got=%0h exp=%0h", i, wd4_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    fill_identity4(); clear_mon();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({busy4, crd4, cwr4, done4} !== 4'b0000) begin failures++; $display("FAIL abort_outputs got=%b exp=0000", {busy4, crd4, cwr4, done4}); end
    checks++; if (cdata_wr4 !== 20'd0) begin failures++; $display("FAIL abort_cdata_wr got=%0h exp=0", cdata_wr4); end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (wa4_q.size() !== 1) begin failures++; $display("FAIL abort_writes got=%0d exp=1", wa4_q.size()); end
    checks++; if (n_done4 !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", n_done4); end
    clear_mon(); run4(n); @(negedge clk);
    checks++; if (n !== 25) begin failures++; $display("FAIL abort_rerun_latency got=%0d exp=25", n); end
    checks++; if (wa4_q.size() !== 4) begin failures++; $display("FAIL abort_rerun_count got=%0d exp=4", wa4_q.size()); end
    if (wa4_q.size() == 4) begin
      checks++; if ({wa4_q[0], wd4_q[0]} !== {2'd0, 20'd5}) begin failures++; $display("FAIL abort_rerun_first got=%0d/%0d exp=0/5", wa4_q[0], wd4_q[0]); end
      checks++; if ({wa4_q[3], wd4_q[3]} !== {2'd3, 20'd15}) begin failures++; $display("FAIL abort_rerun_last got=%0d/%0d exp=3/15", wa4_q[3], wd4_q[3]); end
    end
  endtask

  task automatic test_start_spam();
    int n;
    fill_identity4(); clear_mon();
    @(negedge clk); start4 = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 200);
    start4 = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (n !== 25) begin failures++; $display("FAIL spam_latency got=%0d exp=25", n); end
    checks++; if (wa4_q.size() !== 4) begin failures++; $display("FAIL spam_writes got=%0d exp=4", wa4_q.size()); end
    checks++; if (n_done4 !== 1) begin failures++; $display("FAIL spam_done got=%0d exp=1", n_done4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL spam_idle got=%b exp=0", busy4); end
  endtask

  task automatic test_full64();
    int n, bad, b;
    logic [19:0] expv [1024];
    logic [19:0] m;
    for (int i = 0; i < 4096; i++) mem64[i] = 20'($urandom) & 20'h7FFFF;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        b = 128*r + 2*c;
        m = mem64[b];
        if (mem64[b+1]  > m) m = mem64[b+1];
        if (mem64[b+64] > m) m = mem64[b+64];
        if (mem64[b+65] > m) m = mem64[b+65];
        expv[32*r + c] = m;
      end
    clear_mon();
    @(negedge clk); start64 = 1'b1;
    @(negedge clk); start64 = 1'b0; n = 1;
    while (!done64 && n < 7000) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (n !== 6145) begin failures++; $display("FAIL full_latency got=%0d exp=6145", n); end
    checks++; if (wa64_q.size() !== 1024) begin failures++; $display("FAIL full_count got=%0d exp=1024", wa64_q.size()); end
    bad = 0;
    for (int i = 0; i < wa64_q.size() && i < 1024; i++)
      if (wa64_q[i] !== 10'(i) || wd64_q[i] !== expv[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_data got=%0d bad exp=0 bad", bad); end
    checks++; if (n_ovl64 !== 0) begin failures++; $display("FAIL full_overlap got=%0d exp=0", n_ovl64); end
    checks++; if (n_done64 !== 1) begin failures++; $display("FAIL full_done got=%0d exp=1", n_done64); end
  endtask

  initial begin
    reset = 1'b1; start4 = 1'b0; start64 = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_addr_trace();
    test_signed_tie();
    test_reset_abort();
    test_start_spam();
    test_full64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
